// File: rtl/opram_seq_if.sv
// Operand stream bundle: load stream in, readout stream out.
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface opram_seq_if #(
  parameter int unsigned DW = 8
);
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;

  modport master (
    output wr_valid, wr_data, wr_last, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/opram_seq.sv
// Client-side sequencer for the single-port operand RAM: loads a byte stream
// from address 0 and replays it in order through a 2-entry skid FIFO.
module opram_seq #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  opram_seq_if.slave    bus,
  input  logic          rd_start,
  output logic          busy,
  output logic [AW:0]   fill,
  output logic          ovf,
  output logic          ram_ce,
  output logic          ram_oce,
  output logic          ram_wre,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned FW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fill_d, rp_q, rp_d;
  logic          wr_beat, pop, issue, ovf_d, last_issue;
  logic          inflight_q, inflight_last_q;
  logic [1:0]    occ;
  logic          v0_q, v1_q, l0_q, l1_q;
  logic [DW-1:0] d0_q, d1_q;

  assign ram_oce = 1'b1;

  assign wr_beat    = bus.wr_valid & bus.wr_ready;
  assign pop        = v0_q & bus.rd_ready;
  assign last_issue = (rp_q == fill - FW'(1));
  // Slots committed after this edge; an issue needs one free slot of the two.
  assign occ        = 2'(v0_q) + 2'(v1_q) + 2'(inflight_q) - 2'(pop);

  // Next state and combinational RAM port drive.
  always_comb begin
    state_d = state_q;
    fill_d  = fill;
    rp_d    = rp_q;
    ovf_d   = 1'b0;
    issue   = 1'b0;
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    case (state_q)
      IDLE: begin
        if (wr_beat) begin
          ram_ce  = 1'b1;
          ram_wre = 1'b1;
          ram_din = bus.wr_data;
          fill_d  = FW'(1);
          state_d = bus.wr_last ? IDLE : LOAD;
        end else if (rd_start && (fill != '0)) begin
          rp_d    = '0;
          state_d = READ;
        end
      end
      LOAD: begin
        if (wr_beat) begin
          ram_ce  = 1'b1;
          ram_wre = 1'b1;
          ram_ad  = fill[AW-1:0];
          ram_din = bus.wr_data;
          fill_d  = fill + FW'(1);
          if (bus.wr_last || (fill_d == FW'(DEPTH))) state_d = IDLE;
          ovf_d   = (fill_d == FW'(DEPTH)) && !bus.wr_last;
        end
      end
      READ: begin
        if ((rp_q < fill) && (occ < 2'd2)) begin
          issue  = 1'b1;
          ram_ce = 1'b1;
          ram_ad = rp_q[AW-1:0];
          rp_d   = rp_q + FW'(1);
        end
        if (pop && bus.rd_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      fill            <= '0;
      rp_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      ovf             <= 1'b0;
      busy            <= 1'b0;
      bus.wr_ready    <= 1'b1;
    end else begin
      state_q         <= state_d;
      fill            <= fill_d;
      rp_q            <= rp_d;
      inflight_q      <= issue;
      if (issue) inflight_last_q <= last_issue;
      ovf             <= ovf_d;
      busy            <= (state_d == READ);
      bus.wr_ready    <= (state_d != READ);
    end
  end

  // Skid FIFO, head in slot 0; RAM data lands one cycle after its issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      l0_q <= 1'b0;
      l1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
    end else if (inflight_q && pop) begin
      if (v1_q) begin
        d0_q <= d1_q;
        l0_q <= l1_q;
        d1_q <= ram_dout;
        l1_q <= inflight_last_q;
      end else begin
        d0_q <= ram_dout;
        l0_q <= inflight_last_q;
      end
    end else if (pop) begin
      d0_q <= d1_q;
      l0_q <= l1_q;
      v0_q <= v1_q;
      v1_q <= 1'b0;
    end else if (inflight_q) begin
      if (!v0_q) begin
        d0_q <= ram_dout;
        l0_q <= inflight_last_q;
        v0_q <= 1'b1;
      end else begin
        d1_q <= ram_dout;
        l1_q <= inflight_last_q;
        v1_q <= 1'b1;
      end
    end
  end

  assign bus.rd_valid = v0_q;
  assign bus.rd_data  = d0_q;
  assign bus.rd_last  = v0_q & l0_q;

endmodule

// File: tb/tb_opram_seq.sv
// Directed bench for opram_seq with a bypass-mode RAM model.
module tb_opram_seq;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rd_start = 1'b0;
  logic          busy, ovf, ram_ce, ram_oce, ram_wre;
  logic [AW:0]   fill;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] mem [8];

  int vectors = 0;
  int miscompares = 0;
  int issued = 0;
  int popped = 0;
  logic [7:0] exp_q [$];
  int pat [6] = '{1, 0, 0, 1, 0, 1};

  opram_seq_if #(.DW(DW)) bus ();

  opram_seq #(.DW(DW), .AW(AW), .DEPTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .rd_start (rd_start),
    .busy     (busy),
    .fill     (fill),
    .ovf      (ovf),
    .ram_ce   (ram_ce),
    .ram_oce  (ram_oce),
    .ram_wre  (ram_wre),
    .ram_ad   (ram_ad),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM, bypass output: read data valid the cycle after capture.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      else         ram_dout    <= mem[ram_ad];
    end
  end

  // Running issue/pop counts give the outstanding-entry occupancy.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued <= 0;
      popped <= 0;
    end else begin
      if (ram_ce && !ram_wre)            issued <= issued + 1;
      if (bus.rd_valid && bus.rd_ready)  popped <= popped + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d, input logic last, input logic [2:0] ad);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
    #1;
    check("load_ce",  32'(ram_ce),  32'd1);
    check("load_wre", 32'(ram_wre), 32'd1);
    check("load_ad",  32'(ram_ad),  32'(ad));
    check("load_din", 32'(ram_din), 32'(d));
    step();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  // Request a readout (ignored if already reading) and drain n bytes against exp_q.
  task automatic read_stream(input int n, input int mode);
    int   idx = 0;
    int   cyc = 0;
    logic stalled = 1'b0;
    logic [9:0] held = '0;
    bus.rd_ready = 1'b1;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    while (idx < n && cyc < 200) begin
      bus.rd_ready = (mode == 0) ? 1'b1 : 1'(pat[cyc % 6]);
      #1;
      if (stalled)
        check("stall_hold", 32'({bus.rd_valid, bus.rd_last, bus.rd_data}), 32'(held));
      if (bus.rd_valid && bus.rd_ready) begin
        check("rd_data", 32'(bus.rd_data), 32'(exp_q[idx]));
        check("rd_last", 32'(bus.rd_last), 32'(idx == n - 1));
        idx++;
      end
      stalled = bus.rd_valid && !bus.rd_ready;
      held    = {bus.rd_valid, bus.rd_last, bus.rd_data};
      step();
      check("outstanding", 32'((issued - popped) <= 2), 32'd1);
      cyc++;
    end
    check("stream_count", 32'(idx), 32'(n));
    check("busy_after", 32'(busy), 32'd0);
    check("valid_after", 32'(bus.rd_valid), 32'd0);
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_last",  32'(bus.rd_last),  32'd0);
    check("rst_rd_data",  32'(bus.rd_data),  32'd0);
    check("rst_ovf",      32'(ovf),          32'd0);
    check("rst_fill",     32'(fill),         32'd0);
    check("rst_ram_ce",   32'(ram_ce),       32'd0);
    check("rst_ram_wre",  32'(ram_wre),      32'd0);
    check("rst_ram_ad",   32'(ram_ad),       32'd0);
    check("rst_ram_din",  32'(ram_din),      32'd0);
    check("rst_ram_oce",  32'(ram_oce),      32'd1);
    reset_n = 1'b1;
    step();

    // Three-byte load, readout with exact cycle timing.
    load(8'h11, 1'b0, 3'd0);
    load(8'h22, 1'b0, 3'd1);
    load(8'h33, 1'b1, 3'd2);
    check("t1_fill", 32'(fill), 32'd3);
    check("t1_wr_ready", 32'(bus.wr_ready), 32'd1);
    bus.rd_ready = 1'b1;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    #1;
    check("t1_c1_ce",  32'(ram_ce),       32'd1);
    check("t1_c1_wre", 32'(ram_wre),      32'd0);
    check("t1_c1_ad",  32'(ram_ad),       32'd0);
    check("t1_c1_busy", 32'(busy),        32'd1);
    check("t1_c1_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("t1_c1_valid", 32'(bus.rd_valid), 32'd0);
    step();
    check("t1_c2_valid", 32'(bus.rd_valid), 32'd0);
    check("t1_c2_ad",    32'(ram_ad),       32'd1);
    step();
    check("t1_c3", 32'({bus.rd_valid, bus.rd_last, bus.rd_data}), 32'({2'b10, 8'h11}));
    step();
    check("t1_c4", 32'({bus.rd_valid, bus.rd_last, bus.rd_data}), 32'({2'b10, 8'h22}));
    step();
    check("t1_c5", 32'({bus.rd_valid, bus.rd_last, bus.rd_data}), 32'({2'b11, 8'h33}));
    step();
    check("t1_c6_busy",  32'(busy),         32'd0);
    check("t1_c6_valid", 32'(bus.rd_valid), 32'd0);
    check("t1_c6_fill",  32'(fill),         32'd3);
    bus.rd_ready = 1'b0;

    // Replay of the same contents.
    exp_q = '{8'h11, 8'h22, 8'h33};
    read_stream(3, 0);

    // Eight bytes without wr_last: overflow pulse on the DEPTH-th beat.
    for (int i = 0; i < 8; i++) begin
      load(8'hA0 + 8'(i), 1'b0, 3'(i));
      check("t2_ovf", 32'(ovf), 32'(i == 7));
    end
    check("t2_fill", 32'(fill), 32'd8);
    check("t2_wr_ready", 32'(bus.wr_ready), 32'd1);
    step();
    check("t2_ovf_drop", 32'(ovf), 32'd0);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    read_stream(8, 0);

    // Five bytes drained under toggling backpressure.
    for (int i = 0; i < 5; i++) load(8'h51 + 8'(i), 1'(i == 4), 3'(i));
    check("t3_fill", 32'(fill), 32'd5);
    exp_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    read_stream(5, 1);

    // rd_start with nothing stored is ignored.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    rd_start = 1'b1;
    #1;
    check("t4_empty_ce", 32'(ram_ce), 32'd0);
    step();
    rd_start = 1'b0;
    check("t4_empty_busy", 32'(busy), 32'd0);
    step();
    check("t4_empty_busy2", 32'(busy), 32'd0);
    check("t4_empty_valid", 32'(bus.rd_valid), 32'd0);

    // Load attempt while reading is refused.
    load(8'h61, 1'b0, 3'd0);
    load(8'h62, 1'b1, 3'd1);
    bus.rd_ready = 1'b0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h99;
    #1;
    check("t4_rd_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("t4_rd_wre",      32'(ram_wre),      32'd0);
    check("t4_rd_busy",     32'(busy),         32'd1);
    step();
    check("t4_rd_wre2", 32'(ram_wre), 32'd0);
    check("t4_rd_fill", 32'(fill),    32'd2);
    bus.wr_valid = 1'b0;
    exp_q = '{8'h61, 8'h62};
    read_stream(2, 0);

    // Simultaneous write and rd_start in IDLE: the write wins.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h77;
    bus.wr_last  = 1'b1;
    rd_start     = 1'b1;
    #1;
    check("t4_both_wre", 32'(ram_wre), 32'd1);
    check("t4_both_ad",  32'(ram_ad),  32'd0);
    step();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    rd_start     = 1'b0;
    check("t4_both_fill", 32'(fill), 32'd1);
    check("t4_both_busy", 32'(busy), 32'd0);
    step();
    check("t4_both_busy2",  32'(busy),         32'd0);
    check("t4_both_valid",  32'(bus.rd_valid), 32'd0);
    exp_q = '{8'h77};
    read_stream(1, 0);

    // Reset during the second readout byte clears everything at once.
    load(8'hC1, 1'b0, 3'd0);
    load(8'hC2, 1'b0, 3'd1);
    load(8'hC3, 1'b1, 3'd2);
    bus.rd_ready = 1'b1;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    step();
    check("t5_first", 32'(bus.rd_data), 32'h0C1);
    step();
    check("t5_second", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b1, 8'hC2}));
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(bus.rd_valid), 32'd0);
    check("t5_rst_busy",  32'(busy),         32'd0);
    check("t5_rst_fill",  32'(fill),         32'd0);
    check("t5_rst_last",  32'(bus.rd_last),  32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd_start = 1'b1;
    #1;
    check("t5_post_ce", 32'(ram_ce), 32'd0);
    step();
    rd_start = 1'b0;
    check("t5_post_busy", 32'(busy), 32'd0);
    step();
    check("t5_post_busy2", 32'(busy),         32'd0);
    check("t5_post_valid", 32'(bus.rd_valid), 32'd0);
    bus.rd_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
